// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer interrupt controller:
// config address map, CTRL field layout and a select-width helper.
package timer_pkg;

  localparam logic [1:0] TMR_CMP   = 2'b00;
  localparam logic [1:0] TMR_CTRL  = 2'b01;
  localparam logic [1:0] TMR_PRESC = 2'b10;

  localparam int unsigned CTRL_EN_BIT      = 0;
  localparam int unsigned CTRL_ONESHOT_BIT = 1;

  typedef struct packed {
    logic oneshot;
    logic en;
  } tmr_ctrl_t;

  // A single channel still needs a 1-bit select field.
  function automatic int unsigned sel_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/timer_irq_ctrl_if.sv
// Config-write and interrupt bundle between the CSR/trap side (master) and
// the timer controller (slave).
interface timer_irq_ctrl_if
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned SEL_W  = sel_width(NUM_CH)
);

  logic              cfg_we;
  logic [SEL_W-1:0]  cfg_sel;
  logic [1:0]        cfg_addr;
  logic [CNT_W-1:0]  cfg_wdata;
  logic [NUM_CH-1:0] irq_ack;
  logic [NUM_CH-1:0] irq_pulse;
  logic [NUM_CH-1:0] irq_pending;
  logic              timer_irq;

  modport master (
    output cfg_we, cfg_sel, cfg_addr, cfg_wdata, irq_ack,
    input  irq_pulse, irq_pending, timer_irq
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_addr, cfg_wdata, irq_ack,
    output irq_pulse, irq_pending, timer_irq
  );

endinterface

// File: rtl/timer_channel.sv
// One timer channel: compare counter advanced by the shared tick, with a
// registered fire pulse and a sticky pending flag.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned      CNT_W   = 32,
  parameter logic [CNT_W-1:0] CMP_RST = 'd7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             cmp_we_i,
  input  logic             ctrl_we_i,
  input  logic [CNT_W-1:0] cmp_wdata_i,
  input  tmr_ctrl_t        ctrl_wdata_i,
  input  logic             ack_i,
  output logic             pulse_o,
  output logic             pending_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cmp_q, cmp_d;
  tmr_ctrl_t        ctrl_q, ctrl_d;
  logic             pulse_q, pulse_d;
  logic             pending_q, pending_d;
  logic             load;
  logic             match;
  logic             fire;

  always_comb begin
    load  = cmp_we_i | ctrl_we_i;
    match = (cnt_q == cmp_q);
    // A config write restarts the channel and swallows a coincident fire.
    fire  = ctrl_q.en & tick_i & match & ~load;

    cnt_d  = cnt_q;
    cmp_d  = cmp_q;
    ctrl_d = ctrl_q;
    if (ctrl_q.en && tick_i) begin
      cnt_d = match ? '0 : cnt_q + 1'b1;
    end
    if (fire && ctrl_q.oneshot) begin
      ctrl_d.en = 1'b0;
    end
    if (cmp_we_i) begin
      cmp_d = cmp_wdata_i;
    end
    if (ctrl_we_i) begin
      ctrl_d = ctrl_wdata_i;
    end
    if (load) begin
      cnt_d = '0;
    end

    pulse_d   = fire;
    pending_d = fire | (pending_q & ~ack_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      cmp_q     <= CMP_RST;
      ctrl_q    <= '{oneshot: 1'b0, en: 1'b1};
      pulse_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      cmp_q     <= cmp_d;
      ctrl_q    <= ctrl_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
    end
  end

  assign pulse_o   = pulse_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/timer_irq_ctrl.sv
// Multi-channel periodic/one-shot timer interrupt controller: shared
// prescaler, config decode and the combined machine timer interrupt.
module timer_irq_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned      CNT_W   = 32,
  parameter int unsigned      PRESC_W = 8,
  parameter int unsigned      NUM_CH  = 2,
  parameter logic [CNT_W-1:0] CMP_RST = 'd7
) (
  input  logic             clk,
  input  logic             rst,
  timer_irq_ctrl_if.slave  bus
);

  localparam int unsigned SEL_W = sel_width(NUM_CH);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               tick;
  logic               sel_ok;
  logic               presc_we;
  tmr_ctrl_t          ctrl_wdata;
  logic [NUM_CH-1:0]  cmp_we;
  logic [NUM_CH-1:0]  ctrl_we;
  logic [NUM_CH-1:0]  pulse;
  logic [NUM_CH-1:0]  pending;

  always_comb begin
    sel_ok     = ({1'b0, bus.cfg_sel} < (SEL_W + 1)'(NUM_CH));
    presc_we   = bus.cfg_we & (bus.cfg_addr == TMR_PRESC);
    ctrl_wdata = '{oneshot: bus.cfg_wdata[CTRL_ONESHOT_BIT], en: bus.cfg_wdata[CTRL_EN_BIT]};

    tick    = (pcnt_q == presc_q);
    presc_d = presc_q;
    pcnt_d  = tick ? '0 : pcnt_q + 1'b1;
    if (presc_we) begin
      presc_d = bus.cfg_wdata[PRESC_W-1:0];
      pcnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign cmp_we[i]  = bus.cfg_we & sel_ok & (bus.cfg_sel == SEL_W'(i)) &
                        (bus.cfg_addr == TMR_CMP);
    assign ctrl_we[i] = bus.cfg_we & sel_ok & (bus.cfg_sel == SEL_W'(i)) &
                        (bus.cfg_addr == TMR_CTRL);

    timer_channel #(
      .CNT_W   (CNT_W),
      .CMP_RST (CMP_RST)
    ) u_channel (
      .clk          (clk),
      .rst          (rst),
      .tick_i       (tick),
      .cmp_we_i     (cmp_we[i]),
      .ctrl_we_i    (ctrl_we[i]),
      .cmp_wdata_i  (bus.cfg_wdata),
      .ctrl_wdata_i (ctrl_wdata),
      .ack_i        (bus.irq_ack[i]),
      .pulse_o      (pulse[i]),
      .pending_o    (pending[i])
    );
  end

  assign bus.irq_pulse   = pulse;
  assign bus.irq_pending = pending;
  assign bus.timer_irq   = |pending;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl: inputs change and outputs are sampled
// on the falling edge; expected values are hand-derived cycle counts.
module tb_timer_irq_ctrl;
  import timer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   late_pulses;

  always #5 clk = ~clk;

  timer_irq_ctrl_if #(.CNT_W(32), .NUM_CH(2)) bus ();

  timer_irq_ctrl #(
    .CNT_W   (32),
    .PRESC_W (8),
    .NUM_CH  (2),
    .CMP_RST (32'd7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic sel, input logic [31:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = addr;
    bus.cfg_sel   = sel;
    bus.cfg_wdata = data;
    step(1);
    bus.cfg_we    = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_sel   = '0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus.irq_ack   = '0;
    step(2);
    rst = 1'b0;
    chk("rst_pulse", 32'(bus.irq_pulse), 32'h0);
    chk("rst_pending", 32'(bus.irq_pending), 32'h0);
    chk("rst_irq", 32'(bus.timer_irq), 32'h0);

    // Defaults: period 8, both channels together
    step(7);
    chk("def_c7_pulse", 32'(bus.irq_pulse), 32'h0);
    step(1);
    chk("def_c8_pulse", 32'(bus.irq_pulse), 32'h3);
    chk("def_c8_pending", 32'(bus.irq_pending), 32'h3);
    chk("def_c8_irq", 32'(bus.timer_irq), 32'h1);
    step(1);
    chk("def_c9_pulse", 32'(bus.irq_pulse), 32'h0);
    chk("def_c9_pending", 32'(bus.irq_pending), 32'h3);
    step(7);
    chk("def_c16_pulse", 32'(bus.irq_pulse), 32'h3);
    cfg_write(2'b11, 1'b0, 32'h0);
    chk("rsvd_c17_pulse", 32'(bus.irq_pulse), 32'h0);
    step(6);
    chk("def_c23_pulse", 32'(bus.irq_pulse), 32'h0);
    step(1);
    chk("def_c24_pulse", 32'(bus.irq_pulse), 32'h3);
    bus.irq_ack = 2'b11;
    step(1);
    bus.irq_ack = 2'b00;
    chk("ack_pending", 32'(bus.irq_pending), 32'h0);
    chk("ack_irq", 32'(bus.timer_irq), 32'h0);

    // Prescaler 3, ch0 cmp 2: fire every 12 cycles, ch1 disabled
    cfg_write(TMR_CTRL, 1'b1, 32'h0);
    cfg_write(TMR_PRESC, 1'b0, 32'd3);
    cfg_write(TMR_CMP, 1'b0, 32'd2);
    step(10);
    chk("presc_c11_pulse", 32'(bus.irq_pulse), 32'h0);
    step(1);
    chk("presc_c12_pulse", 32'(bus.irq_pulse), 32'h1);
    chk("presc_c12_pending", 32'(bus.irq_pending), 32'h1);
    step(1);
    chk("presc_c13_pulse", 32'(bus.irq_pulse), 32'h0);
    step(10);
    chk("presc_c23_pulse", 32'(bus.irq_pulse), 32'h0);
    step(1);
    chk("presc_c24_pulse", 32'(bus.irq_pulse), 32'h1);
    step(1);
    chk("presc_c25_pulse", 32'(bus.irq_pulse), 32'h0);

    // One-shot on ch1, ch0 parked
    cfg_write(TMR_CTRL, 1'b0, 32'h0);
    bus.irq_ack = 2'b11;
    cfg_write(TMR_PRESC, 1'b0, 32'd0);
    bus.irq_ack = 2'b00;
    cfg_write(TMR_CMP, 1'b1, 32'd4);
    chk("os_pre_pending", 32'(bus.irq_pending), 32'h0);
    cfg_write(TMR_CTRL, 1'b1, 32'd3);
    step(4);
    chk("os_w5_pulse", 32'(bus.irq_pulse), 32'h0);
    step(1);
    chk("os_w6_pulse", 32'(bus.irq_pulse), 32'h2);
    chk("os_w6_pending", 32'(bus.irq_pending), 32'h2);
    late_pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (bus.irq_pulse != 2'b00) late_pulses++;
    end
    chk("os_no_repeat", 32'(late_pulses), 32'h0);
    chk("os_pending_kept", 32'(bus.irq_pending), 32'h2);

    // Ack collides with fire: set wins
    bus.irq_ack = 2'b10;
    cfg_write(TMR_CMP, 1'b0, 32'd0);
    bus.irq_ack = 2'b00;
    cfg_write(TMR_CTRL, 1'b0, 32'd1);
    chk("col_pre_pending", 32'(bus.irq_pending), 32'h0);
    step(1);
    chk("col_first_pulse", 32'(bus.irq_pulse), 32'h1);
    bus.irq_ack = 2'b01;
    step(1);
    bus.irq_ack = 2'b00;
    chk("col_pending", 32'(bus.irq_pending), 32'h1);
    chk("col_pulse", 32'(bus.irq_pulse), 32'h1);

    // Ack in a quiet cycle, cmp 5
    cfg_write(TMR_CMP, 1'b0, 32'd5);
    chk("cmp5_write_pulse", 32'(bus.irq_pulse), 32'h0);
    bus.irq_ack = 2'b01;
    step(1);
    bus.irq_ack = 2'b00;
    chk("quiet_ack_pending", 32'(bus.irq_pending), 32'h0);
    chk("quiet_ack_irq", 32'(bus.timer_irq), 32'h0);
    step(4);
    chk("cmp5_f6_pulse", 32'(bus.irq_pulse), 32'h0);
    step(1);
    chk("cmp5_f7_pulse", 32'(bus.irq_pulse), 32'h1);

    // CMP write in the match cycle suppresses the fire
    step(5);
    cfg_write(TMR_CMP, 1'b0, 32'd3);
    chk("supp_pulse", 32'(bus.irq_pulse), 32'h0);
    step(3);
    chk("supp_f16_pulse", 32'(bus.irq_pulse), 32'h0);
    step(1);
    chk("supp_f17_pulse", 32'(bus.irq_pulse), 32'h1);

    // Reset mid-count restores defaults
    cfg_write(TMR_CMP, 1'b0, 32'd7);
    step(5);
    chk("mid_pending", 32'(bus.irq_pending), 32'h1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_rst_pulse", 32'(bus.irq_pulse), 32'h0);
    chk("mid_rst_pending", 32'(bus.irq_pending), 32'h0);
    chk("mid_rst_irq", 32'(bus.timer_irq), 32'h0);
    step(7);
    chk("post_rst_c7_pulse", 32'(bus.irq_pulse), 32'h0);
    step(1);
    chk("post_rst_c8_pulse", 32'(bus.irq_pulse), 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_irq_ctrl.md
Name: timer_irq_ctrl

Overview:
- Parametrised, multi-channel successor to the fixed 3-bit periodic timer interrupt.
- Shared programmable prescaler drives NUM_CH independent channels.
- Each channel has its own compare value, enable, and periodic/one-shot mode.
- Each channel produces a one-cycle pulse and a sticky pending flag, cleared by acknowledge. The combined timer_irq feeds the CSR/trap logic as the machine timer interrupt.

Parameters:
- CNT_W, 32: width of channel counters and compare registers.
- PRESC_W, 8: prescaler register width.
- NUM_CH, 2: number of channels (1..8).
- CMP_RST, 7: reset compare value of every channel. Defaults reproduce the legacy 8-cycle period.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cfg_we  in  1  configuration write strobe.
- cfg_sel  in  $clog2(NUM_CH) (min 1)  target channel.
- cfg_addr  in  2  00=CMP, 01=CTRL, 10=PRESC (global), 11=reserved.
- cfg_wdata  in  CNT_W  write data. CTRL uses bit0=en, bit1=oneshot; PRESC uses low PRESC_W bits.
- irq_ack  in  NUM_CH  one-hot/multi-hot pending clear.
- irq_pulse  out  NUM_CH  one-cycle fire strobe per channel.
- irq_pending  out  NUM_CH  sticky pending per channel.
- timer_irq  out  1  OR of irq_pending.

Behaviour:
- Reset (synchronous, clk edge with rst=1):
  - presc=0, prescaler count=0.
  - Every channel: counter=0, cmp=CMP_RST, en=1, oneshot=0.
  - irq_pulse=0, irq_pending=0.
- Tick: asserted in a cycle when prescaler count == presc. On a tick, prescaler count <= 0; otherwise it increments. presc=0 gives a tick every cycle; presc=N gives one every N+1 cycles.
- Channel, enabled, on a tick:
  - If counter != cmp: counter+1.
  - If counter == cmp: fire. Counter <= 0, irq_pulse[i] <= 1 for exactly the next cycle, irq_pending[i] <= 1.
  - If oneshot=1, en <= 0 on that same edge.
- Latency: fire happens at the edge where the match is seen. irq_pulse/pending are visible the following cycle.
  - Default config: first pulse in cycle 8 after rst deasserts (counter 0..7 in cycles 0..7), then every 8 cycles.
- cmp=0: the channel fires on every tick.
- Counter wrap: unreachable, because the match always resets the counter before the CNT_W overflow boundary (cmp <= 2^CNT_W-1). Arithmetic is unsigned, modulo 2^CNT_W.
- Disabled channel: counter holds its value, no fire. irq_pending is retained. Re-enabling via a CTRL write restarts the counter from 0.
- Config writes take effect at the clk edge:
  - CMP or CTRL write to channel s: loads the field and forces counter[s] <= 0, overriding any increment or fire that cycle. A fire in the same cycle is suppressed.
  - PRESC write: loads presc and forces prescaler count <= 0. Channel counters are untouched.
  - addr 11 and out-of-range cfg_sel: ignored, no state change.
- irq_ack[i]=1 clears irq_pending[i]. If a fire and an ack occur on the same edge, set wins and pending stays 1.
- irq_pulse is never affected by irq_ack.
- rst asserted mid-count: all state returns to reset values on that edge. A pending fire is discarded.
- No combinational paths from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package timer_pkg holds:
  - cfg address constants (TMR_CMP, TMR_CTRL, TMR_PRESC).
  - CTRL bit indices (CTRL_EN_BIT, CTRL_ONESHOT_BIT).
  - packed struct tmr_ctrl_t {oneshot, en}.
- One sub-module, timer_channel, instantiated NUM_CH times via generate.
  - Inputs: tick, write-select strobes, cmp/ctrl load data, ack.
  - Outputs: pulse, pending.
- The top level holds the prescaler, address decode and the timer_irq OR.

Test Plan:
- Defaults (presc=0, cmp=7): release rst at cycle 0 -> irq_pulse[0] and irq_pulse[1] high in cycles 8, 16, 24. irq_pending[0] rises in cycle 8 and stays until acked.
- PRESC=3, ch0 CMP=2 -> ticks every 4 cycles, fire every 12 cycles. ch0 pulse period 12, single-cycle width.
- ch1 CTRL=3 (en+oneshot), CMP=4 -> exactly one pulse 5 cycles after the write. ch1 en reads 0 afterwards, and no further pulses over 100 cycles.
- Hold irq_ack[0]=1 in the same cycle ch0 fires (cmp=0, presc=0) -> irq_pending[0] remains 1. Ack in a non-fire cycle (cmp=5) -> cleared the next cycle, timer_irq=0 when ch1 is not pending.
- CMP write to ch0 in the cycle its counter equals the old cmp -> no pulse. Counter restarts at 0 and the next fire occurs new_cmp+1 ticks later.
- Assert rst for one cycle mid-count (counter=5, pending=1) -> all outputs 0 the next cycle. Defaults are restored and the next pulse arrives 8 cycles after rst drops.
